reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Shares one enabled D-register (ports clk/en/d/q) among N_REQ requesters.
//  Round-robin arbitration; the winner's data is written with a one-cycle enable pulse.
//  The register's q is read back and returned to the winner with a one-cycle ack.
//  Sits between requester logic and the shared register; it owns the register's en and d.
// PARAMETERS
//  N_REQ  4  number of requesters (2..16)
//  WIDTH  1  data width of the shared register
// PORTS
//  clk       in   1            rising-edge clock
//  rst       in   1            synchronous reset, active-high
//  req       in   N_REQ        request bits; requester holds its bit until its ack
//  req_data  in   N_REQ*WIDTH  packed; requester i at [i*WIDTH +: WIDTH]
//  ack       out  N_REQ        one-hot, one-cycle completion pulse
//  rd_data   out  WIDTH        register q captured after the write; valid while ack!=0
//  grant_id  out  clog2(N_REQ) index of the current/last winner
//  busy      out  1            1 in any state other than IDLE
//  reg_en    out  1            drives the shared register's en
//  reg_d     out  WIDTH        drives the shared register's d
//  reg_q     in   WIDTH        the shared register's q
// BEHAVIOUR
//  - Reset values: all outputs 0; state=IDLE; last_grant=N_REQ-1, so requester 0 has top priority.
//  - FSM: IDLE -> WRITE -> SETTLE -> ACK -> IDLE. Fixed 4 cycles per grant.
//  - IDLE (cycle t), req!=0:
//    - pick the first set bit searching from last_grant+1, wrapping modulo N_REQ
//    - grant_id<=winner; reg_d<=req_data[winner]
//    - go to WRITE
//  - IDLE, req==0: stay in IDLE; outputs unchanged.
//  - WRITE (t+1): reg_en=1 (decoded from the state register), reg_d stable.
//    The shared register loads on the edge that ends this cycle.
//  - SETTLE (t+2): reg_en=0; rd_data<=reg_q.
//  - ACK (t+3):
//    - ack[grant_id]=1, all other ack bits 0
//    - rd_data valid; last_grant<=grant_id
//  - reg_d and grant_id hold from IDLE capture until the next capture.
//  - req_data is sampled only in IDLE. Changes after capture are ignored.
//  - A req bit dropped mid-transaction does not abort: the write still completes and ack still pulses.
//  - A req bit still high in the IDLE after its ack is re-arbitrated normally.
//    Round robin gives the other requesters priority, so none starves.
//  - rst in any state: next cycle is IDLE with reg_en=0 and ack=0.
//    The interrupted transaction is dropped (never acked); last_grant returns to N_REQ-1.
//  - Only requester i's ack bit can be 1. No ack is issued outside ACK.
// CONFIGURATION
//  - Macro ARB_STATS_EN:
//    - defined: adds output port grant_cnt (N_REQ*8), field i at [i*8 +: 8]
//      - 8-bit count of acks to requester i; incremented in ACK
//      - saturates at 255; cleared by rst
//    - undefined: no port and no counters; behaviour otherwise identical.
// STRUCTURE
//  - Package reg_arb_pkg:
//    - state encoding localparams: IDLE=2'd0, WRITE=2'd1, SETTLE=2'd2, ACK=2'd3
//    - STAT_W=8
//  - Sub-module rr_priority_pick (combinational): inputs req and last_grant;
//    outputs found and winner index. Instantiated once.
//  - Top level holds the FSM, data/ID registers, and the optional stats counters.
// TESTING (N_REQ=4, WIDTH=1; the bench instantiates the real enabled register on reg_en/reg_d/reg_q)
//  1. After rst, req=4'b0100, data[2]=1 at t
//     -> reg_en=1, reg_d=1 at t+1
//     -> ack=4'b0100, rd_data=1 at t+3; busy=0 at t+4
//  2. req=4'b1111 held, data=4'b1010
//     -> acks to 0,1,2,3 in order, one every 4 cycles
//     -> rd_data=0,1,0,1
//  3. req[1] and req[3] held continuously
//     -> grants alternate 1,3,1,3; no grant ever goes to 0 or 2
//  4. rst asserted during WRITE
//     -> next cycle: reg_en=0, ack=0, busy=0
//     -> with req=4'b1111, the next grant goes to 0
//  5. req[2] dropped during SETTLE
//     -> ack[2] still pulses at ACK; rd_data equals the written value
//  6. ARB_STATS_EN: 300 grants to requester 0
//     -> grant_cnt[7:0]=255 and stays there; other fields 0
//     -> after rst, all fields 0

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the register write arbiter.
// Optional feature macro used by the top level: ARB_STATS_EN.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2,
    ACK    = 2'd3
  } arb_state_e;

  localparam int STAT_W = 8;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker: returns the first set request bit found
// when searching upward from last_grant+1, wrapping around to bit 0.
module rr_priority_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  // Scan every candidate once, starting just after the previous winner
  always_comb begin
    int          idx;
    logic [IDX_W-1:0] idx_b;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_b  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx   = (int'(last_grant) + k) % N_REQ;
      idx_b = IDX_W'(idx);
      if (!found && req[idx_b]) begin
        found  = 1'b1;
        winner = idx_b;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares one enabled D-register among N_REQ requesters. Each grant takes a
// fixed four cycles: capture, write pulse, read-back, acknowledge.
// Optional feature macro: ARB_STATS_EN adds per-requester saturating
// acknowledge counters on port grant_cnt.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           ack,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       reg_en,
  output logic [WIDTH-1:0]           reg_d,
  input  logic [WIDTH-1:0]           reg_q
`ifdef ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0]    grant_cnt
`endif
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [WIDTH-1:0] reg_d_q, reg_d_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_winner;

  rr_priority_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req       (req),
    .last_grant(last_grant_q),
    .found     (pick_found),
    .winner    (pick_winner)
  );

  // State and datapath registers; reset drops any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= LAST_RESET;
      reg_d_q      <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      reg_d_q      <= reg_d_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Next state: request data is only sampled while idle
  always_comb begin
    int base;
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    reg_d_d      = reg_d_q;
    rd_data_d    = rd_data_q;
    base         = int'(pick_winner) * WIDTH;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_winner;
          reg_d_d    = req_data[base +: WIDTH];
          state_d    = WRITE;
        end
      end
      WRITE:  state_d = SETTLE;
      SETTLE: begin
        rd_data_d = reg_q;
        state_d   = ACK;
      end
      ACK: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded straight from the registered state
  always_comb begin
    ack    = '0;
    reg_en = (state_q == WRITE);
    busy   = (state_q != IDLE);
    if (state_q == ACK) begin
      ack[grant_id_q] = 1'b1;
    end
  end

  assign grant_id = grant_id_q;
  assign reg_d    = reg_d_q;
  assign rd_data  = rd_data_q;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [N_REQ];
  logic [STAT_W-1:0] cnt_d [N_REQ];

  // Acknowledge counters, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Bump the winner's counter once per acknowledge, holding at the maximum
  always_comb begin
    for (int i = 0; i < N_REQ; i++) cnt_d[i] = cnt_q[i];
    if (state_q == ACK && cnt_q[grant_id_q] != STAT_MAX) begin
      cnt_d[grant_id_q] = cnt_q[grant_id_q] + 1'b1;
    end
  end

  // Flatten the counters onto the packed output port
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) grant_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter with N_REQ=4, WIDTH=1 and a real enabled
// register on reg_en/reg_d/reg_q. Define ARB_STATS_EN to cover the counters.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_data;
  logic [3:0]  ack;
  logic [0:0]  rd_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        reg_en;
  logic [0:0]  reg_d;
  logic [0:0]  reg_q;
  logic [0:0]  shared_q = 1'b0;
`ifdef ARB_STATS_EN
  logic [31:0] grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] data;
    logic [1:0] gid;
    logic       rd;
  } vec_t;

  vec_t vecs[7];

  reg_write_arbiter #(.N_REQ(4), .WIDTH(1)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_data(req_data),
    .ack     (ack),
    .rd_data (rd_data),
    .grant_id(grant_id),
    .busy    (busy),
    .reg_en  (reg_en),
    .reg_d   (reg_d),
    .reg_q   (reg_q)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  // The shared register the arbiter owns
  always_ff @(posedge clk) begin
    if (reg_en) shared_q <= reg_d;
  end
  assign reg_q = shared_q;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
    req      = r;
    req_data = d;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One full transaction from an idle cycle, ending in the following idle cycle
  task automatic runTransaction(input vec_t v);
    checkOutput("vec idle busy", busy, 0);
    applyStimulus(v.req, v.data);
    tick();
    checkOutput("vec write reg_en", reg_en, 1);
    checkOutput("vec write reg_d", reg_d, v.data[v.gid]);
    checkOutput("vec grant_id", grant_id, v.gid);
    tick();
    checkOutput("vec settle reg_en", reg_en, 0);
    checkOutput("vec settle ack", ack, 0);
    tick();
    checkOutput("vec ack", ack, 4'b0001 << v.gid);
    checkOutput("vec rd_data", rd_data, v.rd);
    applyStimulus(4'b0000, v.data);
    tick();
    checkOutput("vec after busy", busy, 0);
    checkOutput("vec after ack", ack, 0);
  endtask

  // Reference winner: first requester at or after last+1, wrapping
  function automatic int pickWinner(input int rq, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (((rq >> i) & 1) == 1) return i;
    end
    return -1;
  endfunction

  initial begin
    int m_since, m_gid, m_last, m_d, m_rd, m_reg, w, rq, dt;
    logic rst_v;

    vecs[0] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[1] = '{4'b1111, 4'b1010, 2'd3, 1'b1};
    vecs[2] = '{4'b1111, 4'b1010, 2'd0, 1'b0};
    vecs[3] = '{4'b0011, 4'b0001, 2'd1, 1'b0};
    vecs[4] = '{4'b0011, 4'b0010, 2'd0, 1'b0};
    vecs[5] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
    vecs[6] = '{4'b0001, 4'b1111, 2'd0, 1'b1};

    applyStimulus(4'b0000, 4'b0000);
    doReset();
    checkOutput("reset ack", ack, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset reg_en", reg_en, 0);
    checkOutput("reset grant_id", grant_id, 0);
    checkOutput("reset reg_d", reg_d, 0);
    checkOutput("reset rd_data", rd_data, 0);

    for (int n = 0; n < 7; n++) runTransaction(vecs[n]);

    // All four requesting: grants rotate 0,1,2,3 back to back
    doReset();
    applyStimulus(4'b1111, 4'b1010);
    for (int k = 0; k < 4; k++) begin
      tick();
      tick();
      tick();
      checkOutput("rotate ack", ack, 4'b0001 << k);
      checkOutput("rotate rd_data", rd_data, (k % 2));
      if (k == 3) applyStimulus(4'b0000, 4'b1010);
      tick();
    end
    checkOutput("rotate end busy", busy, 0);

    // Two requesters held: grants alternate 1,3
    doReset();
    applyStimulus(4'b1010, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      tick();
      tick();
      tick();
      checkOutput("alternate ack", ack, (k % 2 == 0) ? 4'b0010 : 4'b1000);
      if (k == 7) applyStimulus(4'b0000, 4'b0000);
      tick();
    end

    // Reset during WRITE drops the transaction and restores priority to 0
    doReset();
    runTransaction('{4'b0010, 4'b0000, 2'd1, 1'b0});
    applyStimulus(4'b1111, 4'b0000);
    tick();
    checkOutput("rstwr write reg_en", reg_en, 1);
    rst = 1'b1;
    tick();
    checkOutput("rstwr reg_en", reg_en, 0);
    checkOutput("rstwr ack", ack, 0);
    checkOutput("rstwr busy", busy, 0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("rstwr next grant ack", ack, 4'b0001);
    applyStimulus(4'b0000, 4'b0000);
    tick();

    // Request dropped during SETTLE still completes
    applyStimulus(4'b0100, 4'b0100);
    tick();
    tick();
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("drop ack", ack, 4'b0100);
    checkOutput("drop rd_data", rd_data, 1);
    tick();
    checkOutput("drop busy", busy, 0);

    // Randomised traffic against the transaction-level model
    doReset();
    m_since = 0; m_gid = 0; m_last = 3; m_d = 0; m_rd = 0;
    m_reg = int'(shared_q);
    for (int c = 0; c < 600; c++) begin
      rst_v = ($urandom_range(0, 39) == 0);
      rq = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
      dt = int'($urandom_range(0, 15));
      rst = rst_v;
      applyStimulus(rq[3:0], dt[3:0]);
      if (m_since == 1) m_reg = m_d;
      if (rst_v) begin
        m_since = 0; m_gid = 0; m_last = 3; m_d = 0; m_rd = 0;
      end else if (m_since == 0) begin
        w = pickWinner(rq, m_last);
        if (w >= 0) begin
          m_gid = w;
          m_d = (dt >> w) & 1;
          m_since = 1;
        end
      end else if (m_since == 3) begin
        m_last = m_gid;
        m_since = 0;
      end else begin
        if (m_since == 2) m_rd = m_reg;
        m_since++;
      end
      tick();
      checkOutput("rand ack", ack, (m_since == 3) ? (1 << m_gid) : 0);
      checkOutput("rand busy", busy, (m_since != 0) ? 1 : 0);
      checkOutput("rand reg_en", reg_en, (m_since == 1) ? 1 : 0);
      checkOutput("rand grant_id", grant_id, m_gid);
      checkOutput("rand reg_d", reg_d, m_d);
      checkOutput("rand rd_data", rd_data, m_rd);
    end
    rst = 1'b0;

`ifdef ARB_STATS_EN
    // 300 grants to requester 0 saturate its counter at 255
    doReset();
    applyStimulus(4'b0001, 4'b1111);
    repeat (1200) tick();
    checkOutput("stats cnt0 saturated", grant_cnt[7:0], 8'hFF);
    checkOutput("stats other fields", grant_cnt[31:8], 0);
    repeat (8) tick();
    checkOutput("stats cnt0 held", grant_cnt[7:0], 8'hFF);
    applyStimulus(4'b0000, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("stats cleared", grant_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
